// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl: reprograms one PLLE2 output divider over DRP.
// A request holds the PLL in reset, read-modify-writes ClkReg1/ClkReg2 of
// the targeted output, releases reset and waits for a qualified lock.
// Ports:
//   i_clk, i_rst               clock (also DCLK) and sync active-high reset
//   i_req, i_div               start request and requested divide (1..127)
//   o_busy, o_done, o_err      status; done/err are one-cycle pulses
//   o_ready                    synchronized lock while idle
//   o_daddr,o_den,o_dwe,o_di   DRP request side
//   i_do, i_drdy               DRP response side
//   o_pll_rst, i_locked        PLL reset and asynchronous lock indicator
module pll_drp_ctrl #(
  parameter logic [6:0]  CLKREG1_ADDR = 7'h08,
  parameter logic [6:0]  CLKREG2_ADDR = 7'h09,
  parameter int unsigned LOCK_TIMEOUT = 20000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [6:0]  i_div,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_ready,
  output logic [6:0]  o_daddr,
  output logic        o_den,
  output logic        o_dwe,
  output logic [15:0] o_di,
  input  logic [15:0] i_do,
  input  logic        i_drdy,
  output logic        o_pll_rst,
  input  logic        i_locked
);

  localparam int unsigned DIV_W  = 7;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD1       = 4'd1;
  localparam logic [3:0] S_WAIT_RD1  = 4'd2;
  localparam logic [3:0] S_WR1       = 4'd3;
  localparam logic [3:0] S_WAIT_WR1  = 4'd4;
  localparam logic [3:0] S_RD2       = 4'd5;
  localparam logic [3:0] S_WAIT_RD2  = 4'd6;
  localparam logic [3:0] S_WR2       = 4'd7;
  localparam logic [3:0] S_WAIT_WR2  = 4'd8;
  localparam logic [3:0] S_WAIT_LOCK = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              pll_rst_q, pll_rst_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;

  // Divider fields; D==1 is encoded as high=low=1 with no_count set.
  logic [DIV_W-1:0]  high_c, low_c;
  logic              edge_c, no_count_c;
  logic [DATA_W-1:0] reg1_c, reg2_c;

  always_comb begin
    high_c     = (div_q == DIV_W'(1)) ? DIV_W'(1) : (div_q >> 1);
    low_c      = (div_q == DIV_W'(1)) ? DIV_W'(1) : (div_q - high_c);
    edge_c     = div_q[0];
    no_count_c = (div_q == DIV_W'(1));
    // low==64 truncates to 6'd0, which is the hardware encoding for 64.
    reg1_c = (i_do & 16'hF000) | {4'b0000, 6'(high_c), 6'(low_c)};
    reg2_c = (i_do & 16'hFF3F) | {8'h00, edge_c, no_count_c, 6'b000000};
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      daddr_q   <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      di_q      <= '0;
      pll_rst_q <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      daddr_q   <= daddr_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      di_q      <= di_d;
      pll_rst_q <= pll_rst_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
    end
  end

  // Next state; DRP strobes are computed for the state being entered so
  // they are registered and last exactly one cycle.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    daddr_d   = daddr_q;
    den_d     = 1'b0;
    dwe_d     = 1'b0;
    di_d      = di_q;
    pll_rst_d = pll_rst_q;
    sync1_d   = i_locked;
    sync2_d   = sync1_q;

    case (state_q)
      S_IDLE: begin
        // The done cycle is still the tail of the previous operation.
        if (i_req && !done_q) begin
          if (i_div == DIV_W'(0)) begin
            err_d = 1'b1;
          end else begin
            div_d     = i_div;
            pll_rst_d = 1'b1;
            den_d     = 1'b1;
            daddr_d   = CLKREG1_ADDR;
            state_d   = S_RD1;
          end
        end
      end
      S_RD1:      state_d = S_WAIT_RD1;
      S_WAIT_RD1: begin
        if (i_drdy) begin
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          di_d    = reg1_c;
          state_d = S_WR1;
        end
      end
      S_WR1:      state_d = S_WAIT_WR1;
      S_WAIT_WR1: begin
        if (i_drdy) begin
          den_d   = 1'b1;
          daddr_d = CLKREG2_ADDR;
          state_d = S_RD2;
        end
      end
      S_RD2:      state_d = S_WAIT_RD2;
      S_WAIT_RD2: begin
        if (i_drdy) begin
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          di_d    = reg2_c;
          state_d = S_WR2;
        end
      end
      S_WR2:      state_d = S_WAIT_WR2;
      S_WAIT_WR2: begin
        if (i_drdy) begin
          pll_rst_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ignore lock for the first cycles: the synchronizer may still hold
        // a lock level from before the PLL reset.
        if (cnt_q >= CNT_W'(4) && sync2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          err_d     = 1'b1;
          pll_rst_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE) && sync2_d;
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_ready   = ready_q;
  assign o_daddr   = daddr_q;
  assign o_den     = den_q;
  assign o_dwe     = dwe_q;
  assign o_di      = di_q;
  assign o_pll_rst = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Testbench for pll_drp_ctrl: table of divide settings with hand-computed
// register words, plus directed sequences for illegal divide, lock
// timeout, reset mid-operation and requests while busy.
module tb_pll_drp_ctrl;

  localparam int unsigned LT = 300;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic [6:0]  i_div = 7'd0;
  logic        o_busy, o_done, o_err, o_ready;
  logic [6:0]  o_daddr;
  logic        o_den, o_dwe;
  logic [15:0] o_di;
  logic [15:0] i_do = 16'h0;
  logic        i_drdy = 1'b0;
  logic        o_pll_rst;
  logic        i_locked = 1'b0;

  always #5 clk = ~clk;

  pll_drp_ctrl #(
    .CLKREG1_ADDR(7'h08),
    .CLKREG2_ADDR(7'h09),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_div(i_div),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_ready(o_ready),
    .o_daddr(o_daddr), .o_den(o_den), .o_dwe(o_dwe), .o_di(o_di),
    .i_do(i_do), .i_drdy(i_drdy), .o_pll_rst(o_pll_rst), .i_locked(i_locked)
  );

  typedef struct {
    logic [6:0]  div;
    logic [15:0] do1;
    logic [15:0] do2;
    logic [15:0] wr1;
    logic [15:0] wr2;
  } vec_t;

  vec_t vecs[6];

  int applied = 0;
  int miscompares = 0;

  // DRP slave / PLL model state
  logic        pend = 1'b0;
  logic [15:0] pend_data = 16'h0;
  logic [15:0] cur_do1 = 16'h0, cur_do2 = 16'h0;
  int          rel_cnt = 1000;
  bit          lock_ok = 1'b1;
  int          n_txn = 0;
  logic [6:0]  txn_addr[4];
  logic        txn_we[4];
  logic [15:0] txn_di[4];
  int          proto_err = 0;
  int          n_done = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs after the edge, then play DRP slave and PLL.
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_dwe && !o_den) proto_err++;
    if (o_den && pend) proto_err++;
    i_drdy = pend;
    i_do   = pend ? pend_data : 16'h0;
    pend   = 1'b0;
    if (o_den) begin
      if (n_txn < 4) begin
        txn_addr[n_txn] = o_daddr;
        txn_we[n_txn]   = o_dwe;
        txn_di[n_txn]   = o_di;
      end
      n_txn++;
      pend      = 1'b1;
      pend_data = (o_daddr == 7'h08) ? cur_do1 : cur_do2;
    end
    if (o_pll_rst) rel_cnt = 0;
    else if (rel_cnt < 100000) rel_cnt++;
    i_locked = lock_ok && !o_pll_rst && (rel_cnt >= 100);
    if (o_done) n_done++;
    if (o_err) n_err++;
  endtask

  task automatic clear_log();
    n_txn = 0; n_done = 0; n_err = 0;
    for (int k = 0; k < 4; k++) begin
      txn_addr[k] = 7'h0; txn_we[k] = 1'b0; txn_di[k] = 16'h0;
    end
  endtask

  // Issue a request and run until done/err; e_cyc is the first cycle with
  // the PLL reset released, end_cyc the cycle of the done/err pulse.
  task automatic run_req(input logic [6:0] div, input bit spam,
                         output int e_cyc, output int end_cyc);
    e_cyc = -1;
    end_cyc = -1;
    clear_log();
    i_div = div;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    check("accept_busy_den_rst", {29'd0, o_busy, o_den, o_pll_rst}, 32'h7);
    check("accept_addr", {25'd0, o_daddr}, 32'h08);
    for (int cyc = 2; cyc <= 3000; cyc++) begin
      i_req = spam && (cyc >= 3) && (cyc <= 50);
      tick();
      if (e_cyc < 0 && !o_pll_rst && o_busy) e_cyc = cyc;
      if (o_done || o_err) begin
        end_cyc = cyc;
        break;
      end
    end
    i_req = 1'b0;
    if (end_cyc < 0) begin
      applied++;
      miscompares++;
      $display("FAIL run_timeout: got no done/err expected one within 3000 cycles");
    end
  endtask

  task automatic check_txns(input logic [15:0] wr1, input logic [15:0] wr2);
    check("txn_count", n_txn, 4);
    check("txn_seq", {txn_addr[0], txn_we[0], txn_addr[1], txn_we[1],
                      txn_addr[2], txn_we[2], txn_addr[3], txn_we[3]},
          {7'h08, 1'b0, 7'h08, 1'b1, 7'h09, 1'b0, 7'h09, 1'b1});
    check("wr1_data", {16'd0, txn_di[1]}, {16'd0, wr1});
    check("wr2_data", {16'd0, txn_di[3]}, {16'd0, wr2});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e_cyc, end_cyc;

    vecs[0] = '{7'd50,  16'hF000, 16'h00A5, 16'hF659, 16'h0025};
    vecs[1] = '{7'd7,   16'h0000, 16'h0000, 16'h00C4, 16'h0080};
    vecs[2] = '{7'd1,   16'h0000, 16'h0000, 16'h0041, 16'h00C0};
    vecs[3] = '{7'd127, 16'h0000, 16'h0000, 16'h0FC0, 16'h0080};
    vecs[4] = '{7'd2,   16'hFFFF, 16'hFFFF, 16'hF041, 16'hFF3F};
    vecs[5] = '{7'd64,  16'h1234, 16'h12F4, 16'h1820, 16'h1234};

    // Reset values
    i_rst = 1'b1;
    tick();
    tick();
    check("reset_outputs", {o_busy, o_done, o_err, o_ready, o_den, o_dwe, o_pll_rst,
                            o_daddr, o_di}, 32'h0);
    i_rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("ready_idle_locked", {31'd0, o_ready}, 32'h1);

    // Table of divide settings
    for (int v = 0; v < 6; v++) begin
      cur_do1 = vecs[v].do1;
      cur_do2 = vecs[v].do2;
      lock_ok = 1'b1;
      run_req(vecs[v].div, 1'b0, e_cyc, end_cyc);
      check_txns(vecs[v].wr1, vecs[v].wr2);
      check("release_cycle", e_cyc, 9);
      check("done_err_counts", {n_done[15:0], n_err[15:0]}, 32'h0001_0000);
      check("end_busy_rst", {30'd0, o_busy, o_pll_rst}, 32'h0);
      // A request in the done cycle must be ignored.
      i_div = 7'd7;
      i_req = 1'b1;
      tick();
      i_req = 1'b0;
      check("req_on_done_ignored", {29'd0, o_busy, o_den, o_ready}, 32'h1);
      for (int k = 0; k < 3; k++) tick();
    end

    // Illegal divide
    clear_log();
    i_div = 7'd0;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    check("div0_err_pulse", {29'd0, o_err, o_busy, o_den}, 32'h4);
    tick();
    check("div0_err_clear", {29'd0, o_err, o_busy, o_den}, 32'h0);
    for (int k = 0; k < 3; k++) tick();
    check("div0_no_drp", n_txn, 0);

    // Lock timeout
    cur_do1 = 16'h0;
    cur_do2 = 16'h0;
    lock_ok = 1'b0;
    run_req(7'd50, 1'b0, e_cyc, end_cyc);
    check("timeout_latency", end_cyc - e_cyc, LT);
    check("timeout_counts", {n_done[15:0], n_err[15:0]}, 32'h0000_0001);
    check("timeout_end_state", {30'd0, o_busy, o_pll_rst}, 32'h0);
    lock_ok = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    // Reset during WAIT_RD2, then a normal run with requests while busy
    cur_do1 = 16'hF000;
    cur_do2 = 16'h00A5;
    clear_log();
    i_div = 7'd50;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("midop_reset", {o_busy, o_done, o_err, o_ready, o_den, o_dwe, o_pll_rst,
                          o_daddr, o_di}, 32'h0);
    tick();
    check("midop_stays_idle", {30'd0, o_busy, o_den}, 32'h0);
    run_req(7'd50, 1'b1, e_cyc, end_cyc);
    check_txns(16'hF659, 16'h0025);
    check("recovery_done", {n_done[15:0], n_err[15:0]}, 32'h0001_0000);
    tick();
    check("recovery_ready", {31'd0, o_ready}, 32'h1);

    check("drp_protocol", proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
